cla_adder_8bit: RTL and testbench

//   8-bit carry-lookahead adder computing {cout,sum} = a + b + cin.
//   Two-level lookahead: 4-bit CLA groups plus a group-carry unit. No ripple chain.

---
 rtl/cla_adder_8bit_pkg.sv | 18 +
 rtl/cla_adder_8bit_cla4.sv | 40 ++++
 rtl/cla_adder_8bit.sv | 85 ++++++++
 tb/tb_cla_adder_8bit.sv | 138 +++++++++++++
 4 files changed

// File: rtl/cla_adder_8bit_pkg.sv
// Package: cla_adder_8bit_pkg
// Purpose : Shared constants and types for the two-level carry-lookahead adder.
//   ClaWidth  - operand width of the adder (fixed at 8, must be a multiple of 4)
//   GrpWidth  - width of one lookahead group
//   ClaNGrp   - number of 4-bit groups
//   grp_pg_t  - group generate/propagate pair produced by each 4-bit group
package cla_adder_8bit_pkg;

  localparam int unsigned ClaWidth = 8;
  localparam int unsigned GrpWidth = 4;
  localparam int unsigned ClaNGrp  = ClaWidth / GrpWidth;

  typedef struct packed {
    logic gg;  // group generate: the group produces a carry on its own
    logic pg;  // group propagate: the group passes its carry-in straight through
  } grp_pg_t;

endpackage

// File: rtl/cla_adder_8bit_cla4.sv
// Module : cla_4bit
// Purpose: Purely combinational 4-bit carry-lookahead group. Internal carries are
//          flattened sum-of-products of g/p/ci, so no carry is derived from another.
// Ports  :
//   a  [3:0] in  - addend A slice
//   b  [3:0] in  - addend B slice
//   ci       in  - carry into the group
//   s  [3:0] out - sum bits of the group
//   pg       out - group propagate (p3&p2&p1&p0)
//   gg       out - group generate  (g3|p3g2|p3p2g1|p3p2p1g0)
module cla_4bit
  import cla_adder_8bit_pkg::*;
(
  input  logic [GrpWidth-1:0] a,
  input  logic [GrpWidth-1:0] b,
  input  logic                ci,
  output logic [GrpWidth-1:0] s,
  output logic                pg,
  output logic                gg
);

  logic [GrpWidth-1:0] g;
  logic [GrpWidth-1:0] p;
  logic [GrpWidth-1:0] c;

  always_comb begin
    g = a & b;
    p = a ^ b;

    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

    s  = p ^ c;
    pg = &p;
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  end

endmodule

// File: rtl/cla_adder_8bit.sv
// Module : cla_adder_8bit
// Purpose: 8-bit two-level carry-lookahead adder, {cout,sum} = a + b + cin, with a
//          single output register so it acts as a 1-cycle pipeline stage.
// Ports  :
//   clk            in  - rising-edge clock
//   rst            in  - synchronous, active-high reset; clears sum/cout
//   a    [WIDTH-1] in  - addend A, unsigned
//   b    [WIDTH-1] in  - addend B, unsigned
//   cin            in  - carry in
//   sum  [WIDTH-1] out - registered low WIDTH bits of a+b+cin
//   cout           out - registered carry out of bit WIDTH-1
module cla_adder_8bit
  import cla_adder_8bit_pkg::*;
#(
  parameter int unsigned WIDTH = ClaWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned NGRP = WIDTH / GrpWidth;

  grp_pg_t [NGRP-1:0] grp;
  logic    [NGRP:0]   c_grp;   // c_grp[k] = carry into group k, c_grp[NGRP] = cout
  logic [WIDTH-1:0]   sum_d;
  logic               cout_d;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;

  for (genvar i = 0; i < NGRP; i++) begin : g_grp
    cla_4bit u_cla_4bit (
      .a  (a[i*GrpWidth +: GrpWidth]),
      .b  (b[i*GrpWidth +: GrpWidth]),
      .ci (c_grp[i]),
      .s  (sum_d[i*GrpWidth +: GrpWidth]),
      .pg (grp[i].pg),
      .gg (grp[i].gg)
    );
  end

  // Group-carry unit. Each group carry is built as an independent sum of products:
  //   c_grp[k] = OR_j<k (G_j & P_j+1..P_k-1) | (P_0..P_k-1 & cin)
  // For WIDTH=8 this is C4 = G0|P0&cin and cout = G1|P1&G0|P1&P0&cin. The loops only
  // enumerate product terms; no group carry feeds another.
  always_comb begin
    logic term;
    logic all_p;
    c_grp    = '0;
    c_grp[0] = cin;
    for (int k = 1; k <= int'(NGRP); k++) begin
      all_p = 1'b1;
      for (int m = 0; m < k; m++) begin
        all_p = all_p & grp[m].pg;
      end
      c_grp[k] = all_p & cin;
      for (int j = 0; j < k; j++) begin
        term = grp[j].gg;
        for (int m = j + 1; m < k; m++) begin
          term = term & grp[m].pg;
        end
        c_grp[k] = c_grp[k] | term;
      end
    end
    cout_d = c_grp[NGRP];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_cla_adder_8bit.sv
// Testbench for cla_adder_8bit: a driver pushes the expected result of every
// applied vector into a scoreboard queue; a monitor pops one entry after each
// rising edge and compares it against the registered outputs.
module tb_cla_adder_8bit;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic [7:0] sum;
  logic       cout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [8:0] exp;
    string      tag;
  } exp_t;

  exp_t sb_q[$];

  cla_adder_8bit dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 9-bit unsigned addition, forced to zero under reset.
  function automatic logic [8:0] ref_model(input logic r, input logic [7:0] av,
                                           input logic [7:0] bv, input logic ci);
    int unsigned total;
    if (r) return 9'd0;
    total = int'(av) + int'(bv) + int'(ci);
    return total[8:0];
  endfunction

  // Apply one vector away from the active edge and record what the next edge must produce.
  task automatic drive(input logic r, input logic [7:0] av, input logic [7:0] bv,
                       input logic ci, input string tag);
    exp_t e;
    @(negedge clk);
    rst = r;
    a   = av;
    b   = bv;
    cin = ci;
    e.exp = ref_model(r, av, bv, ci);
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  // Monitor: every edge consumes exactly one expected entry once stimulus has started.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if ({cout, sum} !== e.exp) begin
          errors++;
          $display("FAIL %s: got cout=%0b sum=%02h, want cout=%0b sum=%02h",
                   e.tag, cout, sum, e.exp[8], e.exp[7:0]);
        end
      end
    end
  end

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    logic       rr;

    rst = 1'b1;
    a   = 8'hFC;
    b   = 8'h3E;
    cin = 1'b0;

    // Reset held with live operands.
    drive(1'b1, 8'hFC, 8'h3E, 1'b0, "reset_0");
    drive(1'b1, 8'hFC, 8'h3E, 1'b1, "reset_1");

    // Directed vectors.
    drive(1'b0, 8'h00, 8'h00, 1'b0, "zero");
    drive(1'b0, 8'hFC, 8'h3E, 1'b0, "fc_3e");
    drive(1'b0, 8'h78, 8'h08, 1'b0, "78_08");
    drive(1'b0, 8'hFF, 8'h00, 1'b1, "full_propagate");
    drive(1'b0, 8'hFF, 8'hFF, 1'b1, "ff_ff_1");

    // Back-to-back stream, reset mid-stream, then resume.
    drive(1'b0, 8'h12, 8'h34, 1'b0, "stream_0");
    drive(1'b0, 8'hA5, 8'h5A, 1'b1, "stream_1");
    drive(1'b0, 8'h80, 8'h80, 1'b0, "stream_2");
    drive(1'b1, 8'hEE, 8'h77, 1'b1, "stream_rst");
    drive(1'b0, 8'hC3, 8'h4D, 1'b1, "stream_resume");
    drive(1'b0, 8'h0F, 8'hF1, 1'b0, "stream_resume_2");

    // Propagate corners: b = ~a makes every bit propagate.
    for (int i = 0; i < 256; i++) begin
      ra = 8'(i);
      drive(1'b0, ra, ~ra, 1'b1, "prop_cin1");
      drive(1'b0, ra, ~ra, 1'b0, "prop_cin0");
    end

    // Random traffic with occasional reset pulses.
    for (int i = 0; i < 6000; i++) begin
      ra = 8'($urandom_range(255));
      rb = 8'($urandom_range(255));
      rc = 1'($urandom_range(1));
      rr = ($urandom_range(31) == 0);
      drive(rr, ra, rb, rc, rr ? "rand_rst" : "rand");
    end

    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending results, want 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
